// File: rtl/down_counter_ctrl.sv
// Upstream controller for the 8-bit down_counter: prescaled enable generation,
// stop-value monitoring and a one-cycle completion pulse.
module down_counter_ctrl #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic [PRE_W-1:0] prescale,
    input  logic [WIDTH-1:0] stop_value,
    input  logic [WIDTH-1:0] count,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] tick_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        DONE
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] prescale_latched;
    logic [WIDTH-1:0] stop_latched;
    logic             at_stop;
    logic             pre_wrap;

    assign at_stop  = (count == stop_latched);
    assign pre_wrap = (pre_cnt == prescale_latched);

    // NOTE: enable is combinational so the counter decrements on the same edge
    // that the prescaler wraps; gating with abort/hold/at_stop prevents overshoot.
    assign enable = (state == RUN) && pre_wrap && !at_stop && !abort && !hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            pre_cnt          <= '0;
            prescale_latched <= '0;
            stop_latched     <= '0;
            tick_cnt         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        prescale_latched <= prescale;
                        stop_latched     <= stop_value;
                        pre_cnt          <= '0;
                        tick_cnt         <= '0;
                        busy             <= 1'b1;
                        state            <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (at_stop) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (hold) begin
                        state <= HOLD;
                    end else begin
                        pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
                        // tick_cnt saturates rather than wrapping
                        if (enable && (tick_cnt != '1)) begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!hold) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Self-checking bench for down_counter_ctrl: directed scenarios plus random runs
// against a cycle-level behavioural model; the bench also plays the down_counter.
module tb_down_counter_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] prescale = '0;
    logic [7:0] stop_value = '0;
    logic [7:0] cnt = '0;
    logic       enable;
    logic       busy;
    logic       done;
    logic [7:0] tick_cnt;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model
    bit         m_active;
    bit         m_held;
    bit         m_finish;
    int         m_pre;
    logic [7:0] m_stop;
    int         m_phase;
    int         m_ticks;
    bit         env_on = 1'b1;

    down_counter_ctrl #(.WIDTH(8), .PRE_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .hold(hold),
        .prescale(prescale),
        .stop_value(stop_value),
        .count(cnt),
        .enable(enable),
        .busy(busy),
        .done(done),
        .tick_cnt(tick_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_held = 0; m_finish = 0;
        m_pre = 0; m_stop = '0; m_phase = 0; m_ticks = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".enable"}, {31'd0, enable}, 32'd0);
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".done"}, {31'd0, done}, 32'd0);
        check({tag, ".tick"}, {24'd0, tick_cnt}, 32'd0);
    endtask

    // One clock cycle: apply inputs, check at negedge, advance model and counter.
    task automatic cycle(input bit s, input bit a, input bit h);
        bit exp_en;
        bit en_seen;
        start = s; abort = a; hold = h;
        @(negedge clk);
        exp_en = m_active && !m_held && ((m_phase % (m_pre + 1)) == m_pre)
                 && (cnt != m_stop) && !a && !h;
        check("enable", {31'd0, enable}, {31'd0, exp_en});
        check("busy", {31'd0, busy}, {31'd0, m_active});
        check("done", {31'd0, done}, {31'd0, m_finish});
        check("tick_cnt", {24'd0, tick_cnt}, m_ticks);
        en_seen = enable;
        if (m_finish) begin
            m_finish = 0;
        end else if (!m_active) begin
            if (s) begin
                m_active = 1; m_held = 0; m_pre = prescale; m_stop = stop_value;
                m_phase = 0; m_ticks = 0;
            end
        end else if (a) begin
            m_active = 0; m_held = 0;
        end else if (!m_held) begin
            if (cnt == m_stop) begin
                m_active = 0; m_finish = 1;
            end else if (h) begin
                m_held = 1;
            end else begin
                m_phase++;
                if (exp_en) m_ticks = (m_ticks >= 255) ? 255 : m_ticks + 1;
            end
        end else if (!h) begin
            m_held = 0;
        end
        @(posedge clk);
        #1;
        if (en_seen && env_on) cnt = cnt - 8'd1;
        start = 0; abort = 0; hold = 0;
    endtask

    task automatic setup(input int pre, input int c, input int stp);
        prescale = 8'(pre); cnt = 8'(c); stop_value = 8'(stp);
    endtask

    initial begin
        model_reset();
        // 1: reset held for two cycles, then idle with no start
        #1 check_zero("in_reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) cycle(0, 0, 0);

        // 2: prescale 0, 10 down to 5
        setup(0, 10, 5);
        cycle(1, 0, 0);
        repeat (8) cycle(0, 0, 0);
        check("t2.count", {24'd0, cnt}, 32'd5);
        check("t2.tick", {24'd0, tick_cnt}, 32'd5);

        // 3: prescale 3, 4 down to 0, no wrap
        setup(3, 4, 0);
        cycle(1, 0, 0);
        repeat (20) cycle(0, 0, 0);
        check("t3.count", {24'd0, cnt}, 32'd0);
        check("t3.tick", {24'd0, tick_cnt}, 32'd4);

        // 4: hold for 7 cycles mid-run
        setup(3, 4, 0);
        cycle(1, 0, 0);
        repeat (6) cycle(0, 0, 0);
        repeat (7) cycle(0, 0, 1);
        repeat (20) cycle(0, 0, 0);
        check("t4.count", {24'd0, cnt}, 32'd0);
        check("t4.tick", {24'd0, tick_cnt}, 32'd4);

        // 5: abort after two enables, start during RUN ignored
        setup(0, 20, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        repeat (3) cycle(0, 0, 0);
        check("t5.tick", {24'd0, tick_cnt}, 32'd2);
        check("t5.count", {24'd0, cnt}, 32'd18);

        // 6: already at stop, then async reset mid-run
        setup(0, 9, 9);
        cycle(1, 0, 0);
        repeat (3) cycle(0, 0, 0);
        check("t6.tick", {24'd0, tick_cnt}, 32'd0);
        setup(1, 30, 0);
        cycle(1, 0, 0);
        repeat (5) cycle(0, 0, 0);
        reset = 1'b1;
        #1 check_zero("async_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) cycle(0, 0, 0);

        // wrap-around: stop above count
        setup(0, 3, 250);
        cycle(1, 0, 0);
        repeat (12) cycle(0, 0, 0);
        check("wrap.count", {24'd0, cnt}, 32'd250);
        check("wrap.tick", {24'd0, tick_cnt}, 32'd9);

        // tick_cnt saturation: counter held still so the run never matches
        env_on = 0;
        setup(0, 10, 0);
        cycle(1, 0, 0);
        repeat (300) cycle(0, 0, 0);
        check("sat.tick", {24'd0, tick_cnt}, 32'd255);
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        env_on = 1;

        // randomized runs
        for (int r = 0; r < 30; r++) begin
            int c;
            c = int'($urandom_range(0, 255));
            setup(int'($urandom_range(0, 4)), c, (c - int'($urandom_range(0, 10))) & 255);
            cycle(1, 0, 0);
            for (int k = 0; k < 80; k++) begin
                bit s, a, h;
                s = ($urandom_range(0, 9) == 0);
                a = ($urandom_range(0, 59) == 0);
                h = ($urandom_range(0, 5) == 0);
                cycle(s, a, h);
                if (!m_active && !m_finish) break;
            end
            repeat (2) cycle(0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
